// File: rtl/gprf_wb_arbiter.sv
// rtl/gprf_wb_arbiter.sv - two-requester GPRF writeback arbiter with starvation guard and pending scoreboard
module gprf_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [4:0]        req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [4:0]        req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic              resv_valid,
   input  logic [4:0]        resv_addr,
   output logic [4:0]        address_W,
   output logic [DATA_W-1:0] write_data,
   output logic              write_enable,
   output logic [31:0]       pending_mask
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W:0] TRIP = (CNT_W + 1)'(STARVE_LIMIT - 1);

   typedef enum logic {PRIO0, PRIO1} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W:0]   cnt_inc;
   logic             acc0;
   logic             acc1;
   logic [31:0]      pending_next;

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst) begin
         if (state == PRIO1) begin
            if (req1_valid)      req1_ready = 1'b1;
            else if (req0_valid) req0_ready = 1'b1;
         end else begin
            if (req0_valid)      req0_ready = 1'b1;
            else if (req1_valid) req1_ready = 1'b1;
         end
      end
   end

   assign acc0    = req0_valid & req0_ready;
   assign acc1    = req1_valid & req1_ready;
   assign cnt_inc = {1'b0, wait_cnt} + 1'b1;

   // A reservation on the same edge as the clearing accept wins: it is a new in-flight write.
   always_comb begin
      pending_next = pending_mask;
      if (acc1)       pending_next[req1_addr] = 1'b0;
      if (resv_valid) pending_next[resv_addr] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= PRIO0;
         wait_cnt     <= '0;
         address_W    <= '0;
         write_data   <= '0;
         write_enable <= 1'b0;
         pending_mask <= '0;
      end else begin
         pending_mask <= pending_next;

         if (acc0) begin
            write_enable <= (req0_addr != 5'd0);
            if (req0_addr != 5'd0) begin
               address_W  <= req0_addr;
               write_data <= req0_data;
            end
         end else if (acc1) begin
            write_enable <= (req1_addr != 5'd0);
            if (req1_addr != 5'd0) begin
               address_W  <= req1_addr;
               write_data <= req1_data;
            end
         end else begin
            write_enable <= 1'b0;
         end

         // Blocked req1 counts up; the cycle the count reaches the limit-1 flips priority.
         if (!req1_valid || acc1) begin
            wait_cnt <= '0;
            state    <= PRIO0;
         end else begin
            wait_cnt <= cnt_inc[CNT_W-1:0];
            if (cnt_inc >= TRIP) state <= PRIO1;
         end
      end
   end

endmodule

// File: tb/tb_gprf_wb_arbiter.sv
// tb/tb_gprf_wb_arbiter.sv - directed vector bench for gprf_wb_arbiter
module tb_gprf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, resv_valid;
   logic [4:0]  req0_addr, req1_addr, resv_addr;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic [4:0]  address_W;
   logic [31:0] write_data;
   logic        write_enable;
   logic [31:0] pending_mask;

   logic [31:0] gprf [32];
   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   gprf_wb_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .resv_valid(resv_valid), .resv_addr(resv_addr),
      .address_W(address_W), .write_data(write_data), .write_enable(write_enable),
      .pending_mask(pending_mask)
   );

   always @(posedge clk) begin
      if (write_enable) gprf[address_W] <= write_data;
   end

   typedef struct {
      logic        r0v; logic [4:0] r0a; logic [31:0] r0d;
      logic        r1v; logic [4:0] r1a; logic [31:0] r1d;
      logic        sv;  logic [4:0] sa;
      logic        e_r0; logic e_r1; logic e_we;
      logic [4:0]  e_aw; logic [31:0] e_wd; logic chk_ad;
      logic [31:0] e_pm;
   } vec_t;

   function automatic vec_t mk(logic r0v, logic [4:0] r0a, logic [31:0] r0d,
                               logic r1v, logic [4:0] r1a, logic [31:0] r1d,
                               logic sv, logic [4:0] sa,
                               logic e_r0, logic e_r1, logic e_we,
                               logic [4:0] e_aw, logic [31:0] e_wd, logic chk_ad,
                               logic [31:0] e_pm);
      vec_t v;
      v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
      v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
      v.sv = sv; v.sa = sa;
      v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_we = e_we;
      v.e_aw = e_aw; v.e_wd = e_wd; v.chk_ad = chk_ad; v.e_pm = e_pm;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0v, input logic [4:0] r0a, input logic [31:0] r0d,
                        input logic r1v, input logic [4:0] r1a, input logic [31:0] r1d,
                        input logic sv, input logic [4:0] sa);
      req0_valid = r0v; req0_addr = r0a; req0_data = r0d;
      req1_valid = r1v; req1_addr = r1a; req1_data = r1d;
      resv_valid = sv;  resv_addr = sa;
   endtask

   vec_t tbl [15];

   initial begin
      for (int i = 0; i < 32; i++) gprf[i] = 32'h0;

      //        r0v  r0a    r0d            r1v  r1a    r1d            sv   sa     e_r0 e_r1 e_we e_aw   e_wd           chk  e_pm
      tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 5'd0,  1, 0, 1, 5'd5,  32'hDEADBEEF, 1, 32'h0);
      tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0, 0, 0, 5'd5,  32'hDEADBEEF, 1, 32'h0);
      tbl[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  0, 0, 0, 5'd5,  32'hDEADBEEF, 1, 32'h80);
      tbl[3]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0, 0, 0, 5'd5,  32'hDEADBEEF, 1, 32'h80);
      tbl[4]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0, 0, 0, 5'd5,  32'hDEADBEEF, 1, 32'h80);
      tbl[5]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  32'h12345678, 0, 5'd0,  0, 1, 1, 5'd7,  32'h12345678, 1, 32'h0);
      tbl[6]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0, 0, 0, 5'd7,  32'h12345678, 1, 32'h0);
      tbl[7]  = mk(0, 5'd0,  32'h0,        1, 5'd9,  32'hA5A5A5A5, 1, 5'd9,  0, 1, 1, 5'd9,  32'hA5A5A5A5, 1, 32'h200);
      tbl[8]  = mk(1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,        1, 5'd0,  1, 0, 0, 5'd0,  32'h0,        0, 32'h200);
      tbl[9]  = mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h1,        0, 5'd0,  0, 1, 1, 5'd9,  32'h1,        1, 32'h0);
      tbl[10] = mk(1, 5'd3,  32'h33,       1, 5'd4,  32'h44,       0, 5'd0,  1, 0, 1, 5'd3,  32'h33,       1, 32'h0);
      tbl[11] = mk(0, 5'd0,  32'h0,        1, 5'd4,  32'h44,       0, 5'd0,  0, 1, 1, 5'd4,  32'h44,       1, 32'h0);
      tbl[12] = mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd12, 0, 0, 0, 5'd4,  32'h44,       1, 32'h1000);
      tbl[13] = mk(1, 5'd12, 32'hC,        0, 5'd0,  32'h0,        0, 5'd0,  1, 0, 1, 5'd12, 32'hC,        1, 32'h1000);
      tbl[14] = mk(0, 5'd0,  32'h0,        1, 5'd12, 32'hC1,       0, 5'd0,  0, 1, 1, 5'd12, 32'hC1,       1, 32'h0);

      // Reset held with both requesters asking
      rst = 1'b1;
      drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd3);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("rst_ready0", {31'b0, req0_ready}, 32'h0);
         chk("rst_ready1", {31'b0, req1_ready}, 32'h0);
         chk("rst_we", {31'b0, write_enable}, 32'h0);
         chk("rst_pm", pending_mask, 32'h0);
      end
      chk("rst_aw", {27'b0, address_W}, 32'h0);
      chk("rst_wd", write_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(tbl[i].r0v, tbl[i].r0a, tbl[i].r0d, tbl[i].r1v, tbl[i].r1a, tbl[i].r1d, tbl[i].sv, tbl[i].sa);
         #1;
         chk($sformatf("v%0d_ready0", i), {31'b0, req0_ready}, {31'b0, tbl[i].e_r0});
         chk($sformatf("v%0d_ready1", i), {31'b0, req1_ready}, {31'b0, tbl[i].e_r1});
         @(posedge clk); #1;
         chk($sformatf("v%0d_we", i), {31'b0, write_enable}, {31'b0, tbl[i].e_we});
         chk($sformatf("v%0d_pm", i), pending_mask, tbl[i].e_pm);
         if (tbl[i].chk_ad) begin
            chk($sformatf("v%0d_aw", i), {27'b0, address_W}, {27'b0, tbl[i].e_aw});
            chk($sformatf("v%0d_wd", i), write_data, tbl[i].e_wd);
         end
      end
      chk("gprf_r7", gprf[7], 32'h12345678);
      chk("gprf_r9", gprf[9], 32'h1);
      chk("gprf_r0", gprf[0], 32'h0);

      // Starvation guard: both continuously valid, req1 wins every 4th cycle
      @(negedge clk);
      drive(1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222, 0, 5'd0);
      for (int k = 0; k < 12; k++) begin
         #1;
         chk($sformatf("starve%0d_ready1", k), {31'b0, req1_ready}, {31'b0, (k % 4) == 3});
         chk($sformatf("starve%0d_ready0", k), {31'b0, req0_ready}, {31'b0, (k % 4) != 3});
         @(posedge clk); #1;
         chk($sformatf("starve%0d_we", k), {31'b0, write_enable}, 32'h1);
         chk($sformatf("starve%0d_aw", k), {27'b0, address_W}, ((k % 4) == 3) ? 32'd2 : 32'd1);
         @(negedge clk);
      end

      // Reset mid-operation drops the in-flight write and reservations at once
      drive(1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 1, 5'd20);
      @(posedge clk); #1;
      chk("mid_we_before", {31'b0, write_enable}, 32'h1);
      chk("mid_pm_before", pending_mask, 32'h0010_0000);
      #2 rst = 1'b1;
      #1;
      chk("mid_we_async", {31'b0, write_enable}, 32'h0);
      chk("mid_pm_async", pending_mask, 32'h0);
      chk("mid_ready0", {31'b0, req0_ready}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0);
      @(posedge clk); #1;
      chk("post_rst_we", {31'b0, write_enable}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
